// File: rtl/round_key_stage_if.sv
// Handshake bundle around the AddRoundKey stage: upstream beat (mixed/unmixed
// state plus round key) and downstream keyed-state result.
interface round_key_stage_if #(
  parameter int N  = 4,
  parameter int NR = 10
);
  localparam int RW = $clog2(NR + 1);

  logic                        in_valid;
  logic                        in_ready;
  logic [N-1:0][N-1:0][7:0]    state_mixed;
  logic [N-1:0][N-1:0][7:0]    state_unmixed;
  logic [N-1:0][N-1:0][7:0]    round_key;
  logic                        out_valid;
  logic                        out_ready;
  logic [N-1:0][N-1:0][7:0]    state_out;
  logic [RW-1:0]               out_round;
  logic                        out_last;

  modport master (
    output in_valid, state_mixed, state_unmixed, round_key, out_ready,
    input  in_ready, out_valid, state_out, out_round, out_last
  );

  modport slave (
    input  in_valid, state_mixed, state_unmixed, round_key, out_ready,
    output in_ready, out_valid, state_out, out_round, out_last
  );
endinterface

// File: rtl/round_key_stage.sv
// Registered AddRoundKey stage with a 2-entry skid buffer (output register plus
// one skid entry) and a round counter that tags each result 0..NR.
module round_key_stage #(
  parameter int N  = 4,
  parameter int NR = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  round_key_stage_if.slave  bus
);
  localparam int RW = $clog2(NR + 1);
  typedef logic [N-1:0][N-1:0][7:0] state_t;

  state_t        out_data, skid_data, beat_data;
  logic [RW-1:0] round_cnt, out_round_q, skid_round;
  logic          out_valid_q, out_last_q, skid_valid, skid_last, in_ready_q;
  logic          accept, drain, out_load, skid_load, skid_valid_next, beat_last;

  always_comb begin
    beat_last       = (round_cnt == RW'(NR));
    beat_data       = state_t'(((round_cnt == '0) || beat_last) ? bus.state_unmixed
                                                                : bus.state_mixed)
                      ^ bus.round_key;
    accept          = bus.in_valid & in_ready_q & ~flush;
    drain           = out_valid_q & bus.out_ready;
    out_load        = ~out_valid_q | drain;
    // A new beat lands in skid unless it can go straight to the output register.
    skid_load       = accept & ~(out_load & ~skid_valid);
    skid_valid_next = out_load ? (skid_valid & accept) : (skid_valid | accept);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_cnt   <= '0;
      out_data    <= '0;
      out_round_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      skid_data   <= '0;
      skid_round  <= '0;
      skid_last   <= 1'b0;
      skid_valid  <= 1'b0;
      in_ready_q  <= 1'b0;
    end else if (flush) begin
      round_cnt   <= '0;
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      if (accept)
        round_cnt <= beat_last ? '0 : round_cnt + RW'(1);

      if (out_load) begin
        if (skid_valid) begin
          out_data    <= skid_data;
          out_round_q <= skid_round;
          out_last_q  <= skid_last;
          out_valid_q <= 1'b1;
        end else if (accept) begin
          out_data    <= beat_data;
          out_round_q <= round_cnt;
          out_last_q  <= beat_last;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end

      if (skid_load) begin
        skid_data  <= beat_data;
        skid_round <= round_cnt;
        skid_last  <= beat_last;
      end

      skid_valid <= skid_valid_next;
      in_ready_q <= ~skid_valid_next;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.state_out = out_data;
  assign bus.out_round = out_round_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_round_key_stage.sv
// Randomized and directed bench for round_key_stage against a queue-based model
// of the buffered results and the round sequence.
module tb_round_key_stage;
  localparam int N  = 4;
  localparam int NR = 10;
  localparam int RW = $clog2(NR + 1);
  localparam int SW = 8 * N * N;
  typedef logic [N-1:0][N-1:0][7:0] state_t;
  typedef struct {
    state_t        d;
    logic [RW-1:0] r;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_cmp = 0;
  int   n_err = 0;

  ent_t q[$];
  int   mdl_round = 0;
  bit   mdl_rdy   = 1'b0;

  round_key_stage_if #(.N(N), .NR(NR)) bus ();

  round_key_stage #(.N(N), .NR(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic state_t from_bytes(input logic [SW-1:0] b);
    state_t s;
    for (int c = 0; c < N; c++)
      for (int r = 0; r < N; r++)
        s[c][r] = b[SW-1-8*(N*c+r) -: 8];
    return s;
  endfunction

  function automatic state_t rnd_state();
    logic [SW-1:0] v;
    for (int i = 0; i < SW / 32; i++)
      v[32*i +: 32] = $urandom();
    return state_t'(v);
  endfunction

  // AddRoundKey as defined for AES: rounds 0 and NR skip MixColumns.
  function automatic state_t ref_beat(input int r);
    state_t src, res;
    src = (r == 0 || r == NR) ? bus.state_unmixed : bus.state_mixed;
    for (int c = 0; c < N; c++)
      for (int b = 0; b < N; b++)
        res[c][b] = src[c][b] ^ bus.round_key[c][b];
    return res;
  endfunction

  task automatic step();
    bit   acc, drn;
    ent_t e;
    acc = bus.in_valid && mdl_rdy && !flush;
    drn = (q.size() > 0) && bus.out_ready;
    e.d = ref_beat(mdl_round);
    e.r = RW'(mdl_round);
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
      mdl_round = 0;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        mdl_round = (mdl_round == NR) ? 0 : mdl_round + 1;
      end
    end
    mdl_rdy = (q.size() < 2);
    check("out_valid", SW'(bus.out_valid), SW'(q.size() > 0));
    check("in_ready", SW'(bus.in_ready), SW'(mdl_rdy));
    if (q.size() > 0) begin
      check("state_out", bus.state_out, q[0].d);
      check("out_round", SW'(bus.out_round), SW'(q[0].r));
      check("out_last", SW'(bus.out_last), SW'(q[0].r == NR));
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    rst_n             = 1'b0;
    flush             = 1'b0;
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;
    bus.state_mixed   = '0;
    bus.state_unmixed = '0;
    bus.round_key     = '0;
    #12;
    check("rst_out_valid", SW'(bus.out_valid), '0);
    check("rst_state_out", bus.state_out, '0);
    check("rst_out_round", SW'(bus.out_round), '0);
    check("rst_out_last", SW'(bus.out_last), '0);
    rst_n = 1'b1;
    step();

    // FIPS-197 Appendix B, initial AddRoundKey
    bus.state_unmixed = from_bytes(128'h3243f6a8885a308d313198a2e0370734);
    bus.round_key     = from_bytes(128'h2b7e151628aed2a6abf7158809cf4f3c);
    bus.state_mixed   = {(N*N){8'hAA}};
    bus.in_valid      = 1'b1;
    bus.out_ready     = 1'b1;
    step();
    check("fips_state", bus.state_out, from_bytes(128'h193de3bea0f4e22b9ac68d2ae9f84808));
    check("fips_round", SW'(bus.out_round), '0);
    check("fips_last", SW'(bus.out_last), '0);
    bus.in_valid = 1'b0;
    step();

    // Full block of NR+1 beats plus the first beat of the next block
    do_flush();
    bus.state_mixed   = {(N*N){8'hFF}};
    bus.state_unmixed = {(N*N){8'h00}};
    bus.round_key     = {(N*N){8'h0F}};
    bus.in_valid      = 1'b1;
    for (int i = 0; i <= NR + 1; i++) begin
      step();
      check("blk_round", SW'(bus.out_round), SW'(i % (NR + 1)));
      check("blk_state", bus.state_out,
            (i % (NR + 1) == 0 || i == NR) ? {(N*N){8'h0F}} : {(N*N){8'hF0}});
      check("blk_last", SW'(bus.out_last), SW'(i == NR));
    end
    bus.in_valid = 1'b0;
    step();

    // Backpressure, then drain with accepts still offered
    do_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.state_mixed   = rnd_state();
      bus.state_unmixed = rnd_state();
      bus.round_key     = rnd_state();
      step();
    end
    check("bp_in_ready", SW'(bus.in_ready), '0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    bus.in_valid = 1'b0;
    step();
    step();

    // Flush with both entries full around round 5
    do_flush();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    do_flush();
    check("flush_out_valid", SW'(bus.out_valid), '0);
    bus.out_ready = 1'b1;
    step();
    check("flush_next_round", SW'(bus.out_round), '0);

    // Asynchronous reset in the middle of a block
    do_flush();
    for (int i = 0; i < 4; i++) step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", SW'(bus.out_valid), '0);
    check("arst_state_out", bus.state_out, '0);
    check("arst_out_round", SW'(bus.out_round), '0);
    check("arst_out_last", SW'(bus.out_last), '0);
    q.delete();
    mdl_round = 0;
    mdl_rdy   = 1'b0;
    #2 rst_n = 1'b1;
    step();
    step();
    check("arst_next_round", SW'(bus.out_round), '0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      bus.in_valid      = ($urandom_range(3) != 0);
      bus.out_ready     = ($urandom_range(2) != 0);
      flush             = ($urandom_range(39) == 0);
      bus.state_mixed   = rnd_state();
      bus.state_unmixed = rnd_state();
      bus.round_key     = rnd_state();
      step();
    end
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/round_key_stage.md
Name: round_key_stage

Overview:
- Registered AddRoundKey stage directly downstream of mix_columns in the iterative AES datapath.
- Each accepted beat selects either the mix_columns result or the unmixed state, according to the internal round counter, XORs it with the supplied round key, and holds the result in a 2-entry skid buffer.
- The block tracks round number 0..NR and flags the last round of each block to the output collector.

Parameters:
- N, 4, state dimension; state is N columns x N bytes.
- NR, 10, rounds per block (10/12/14 for AES-128/192/256).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of buffers and round counter.
- in_valid  input  1  beat offered on state_mixed/state_unmixed/round_key.
- in_ready  output  1  stage can accept a beat.
- state_mixed  input  8 x N x N  mix_columns output; [c][r] = column c, row r.
- state_unmixed  input  8 x N x N  state bypassing mix_columns: plaintext in round 0, shift_rows output in round NR.
- round_key  input  8 x N x N  round key for the current round, same layout.
- out_valid  output  1  state_out holds a result.
- out_ready  input  1  consumer accepts the result.
- state_out  output  8 x N x N  keyed state.
- out_round  output  $clog2(NR+1)  round index of state_out.
- out_last  output  1  out_round == NR.

Behaviour:
- Reset (rst_n low, asynchronous): both buffer entries empty; out_valid=0; state_out, out_round and out_last = 0; round counter = 0; in_ready=1 from the first clock after deassertion.
- Accept condition: in_valid & in_ready at a rising edge.
- Selection per accepted beat, round counter value r:
  - r==0 or r==NR: source = state_unmixed.
  - 1<=r<=NR-1: source = state_mixed.
- Result = source XOR round_key, bytewise over all N*N bytes. No width growth. The result is stored with tag r.
- Round counter:
  - Increments on each accept.
  - After accepting r==NR, wraps to 0.
  - Width is $clog2(NR+1).
- Latency: one cycle. A beat accepted at edge k appears on state_out with out_valid=1 after edge k if the output register is empty or drains at k.
- Skid buffer:
  - Output register plus one skid entry.
  - in_ready = skid entry empty. It is registered and depends on no combinational path from out_ready.
  - Output register loads whenever it is empty or out_valid & out_ready. It loads from the skid entry if that entry is occupied, otherwise from the new beat.
  - If the output is stalled and a beat is accepted, the beat goes to skid; in_ready falls next cycle.
  - Simultaneous accept and drain while skid is occupied: skid moves to output and the new beat moves to skid. Order is preserved and no beat is lost or duplicated.
  - out_valid=1 with out_ready=0: state_out, out_round and out_last remain stable.
- flush:
  - Next edge: both entries empty, out_valid=0, round counter=0.
  - A beat offered in the flush cycle is dropped.
  - flush has priority over accept and drain.
- Reset mid-block: all state discarded immediately; the next accepted beat is round 0.
- in_valid while in_ready=0: ignored; the upstream holds its data.
- out_last = (out_round == NR), registered with the data.
- No combinational path from any input to out_valid/state_out.

Test Plan:
- Round 0, FIPS-197 App. B:
  - Stimulus: state_unmixed = 32 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 34; round_key = 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c; state_mixed = all 0xAA; out_ready=1.
  - Required: next cycle state_out = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08, out_round=0, out_last=0.
- Full block:
  - Stimulus: 11 back-to-back beats, state_mixed all 0xFF, state_unmixed all 0x00, round_key all 0x0F, out_ready=1.
  - Required: round 0 = all 0x0F; rounds 1..9 = all 0xF0; round 10 = all 0x0F with out_last=1; 12th beat tagged round 0.
- Backpressure:
  - Stimulus: out_ready=0, three beats offered.
  - Required: first two accepted; in_ready=0 from the cycle after the second; third held. Raise out_ready: order 0,1,2 preserved; no duplicates; state_out stable while stalled.
- Simultaneous events:
  - Stimulus: skid full, out_ready=1 and in_valid=1 in the same cycle.
  - Required: only the drain completes, since in_ready=0. Next cycle, accept and drain together keep one entry queued and throughput at 1 beat/cycle.
- flush:
  - Stimulus: assert flush during round 5 with both entries full.
  - Required: out_valid=0 next cycle; the following accepted beat is tagged round 0.
- Async reset:
  - Stimulus: pull rst_n low mid-cycle during round 3.
  - Required: out_valid drops immediately with no clock edge; all outputs are 0; after release, the first beat is round 0.
